// File: rtl/ce_nco_gen.sv
// rtl/ce_nco_gen.sv - multi-channel fractional clock-enable generator (NCO based)
module ce_nco_gen #(
  parameter int                            CHANNELS    = 2,
  parameter int                            ACC_W       = 32,
  parameter int                            LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0]     INIT_INC    = '0
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       en,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       clk_out,
  output logic                      locked
);

  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic [ACC_W-1:0] acc    [CHANNELS];
  logic [ACC_W-1:0] inc_sh [CHANNELS];
  logic [ACC_W:0]   sum    [CHANNELS];

  // Lock state and settle counter registers
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: load always restarts the settle window
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (load) begin
      state_nxt = SETTLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state_nxt = LOCKED;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          state_nxt = LOCKED;
        end
        default: begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // locked is a direct decode of the state flop, so it is glitch-free
  assign locked = (state == LOCKED);

  // Per-channel accumulate with the carry in the MSB of the wide sum
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, inc_sh[i]};
    end
  end

  // Accumulators, shadow increments and registered enable/clock outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        inc_sh[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
      ce      <= '0;
      clk_out <= '0;
    end else if (load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        inc_sh[i] <= inc[i*ACC_W +: ACC_W];
      end
      ce      <= '0;
      clk_out <= '0;
    end else if (state == SETTLE) begin
      // Accumulators were cleared on entry to SETTLE and stay at zero
      ce      <= '0;
      clk_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (en[i]) begin
          acc[i]     <= sum[i][ACC_W-1:0];
          ce[i]      <= sum[i][ACC_W];
          clk_out[i] <= clk_out[i] ^ sum[i][ACC_W];
        end else begin
          ce[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ce_nco_gen.sv
// tb/tb_ce_nco_gen.sv - randomized self-checking bench for ce_nco_gen
module tb_ce_nco_gen;

  localparam int          CH   = 2;
  localparam int          W    = 8;
  localparam int          LC   = 4;
  localparam logic [15:0] INIT = {8'd32, 8'd64};

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic        load   = 1'b0;
  logic [15:0] inc    = '0;
  logic [1:0]  en     = '0;
  logic [1:0]  ce;
  logic [1:0]  clk_out;
  logic        locked;

  int total = 0;
  int bad   = 0;

  // Reference model: output of channel i after its k-th active step is
  // derived from how many times k*inc has crossed a multiple of 2^W.
  int          since;
  longint      kk  [CH];
  longint      shi [CH];
  logic [1:0]  m_ce;
  logic [1:0]  m_clk;
  logic        m_locked;

  ce_nco_gen #(
    .CHANNELS    (CH),
    .ACC_W       (W),
    .LOCK_CYCLES (LC),
    .INIT_INC    (INIT)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .inc     (inc),
    .load    (load),
    .en      (en),
    .ce      (ce),
    .clk_out (clk_out),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  task automatic model_reset();
    since = 0;
    for (int i = 0; i < CH; i++) begin
      kk[i]  = 0;
      shi[i] = longint'(INIT[i*W +: W]);
    end
    m_ce = '0; m_clk = '0; m_locked = 1'b0;
  endtask

  task automatic model_edge();
    longint q, q0;
    if (load) begin
      since = 0;
      for (int i = 0; i < CH; i++) begin
        kk[i]  = 0;
        shi[i] = longint'(inc[i*W +: W]);
      end
      m_ce = '0; m_clk = '0; m_locked = 1'b0;
    end else if (since < LC) begin
      since++;
      m_locked = (since >= LC);
      m_ce = '0; m_clk = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (en[i]) begin
          kk[i]++;
          q  = (kk[i] * shi[i]) >> W;
          q0 = ((kk[i] - 1) * shi[i]) >> W;
          m_ce[i]  = (q != q0);
          m_clk[i] = q[0];
        end else begin
          m_ce[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int got;
    model_reset();
    en = 2'b11;
    #2;
    total++; if (ce !== 2'b00) begin bad++; $display("FAIL reset_ce got=%b exp=00", ce); end
    total++; if (clk_out !== 2'b00) begin bad++; $display("FAIL reset_clk got=%b exp=00", clk_out); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    #10 rst = 1'b0;
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      total++;
      if (locked !== m_locked || ce !== m_ce || clk_out !== m_clk) begin
        bad++; $display("FAIL reset_model n=%0d got %b/%b/%b exp %b/%b/%b", n, locked, ce, clk_out, m_locked, m_ce, m_clk);
      end
      if (locked === 1'b1) begin got = n; break; end
    end
    total++; if (got != LC) begin bad++; $display("FAIL reset_lock_edge got=%0d exp=%0d", got, LC); end
  endtask

  task automatic test_init_rates();
    for (int c = 1; c <= 32; c++) begin
      tick();
      total++;
      if (ce[0] !== ((c % 4) == 0) || ce[1] !== ((c % 8) == 0) || clk_out[0] !== (((c / 4) % 2) == 1)) begin
        bad++; $display("FAIL init_rates c=%0d ce=%b clk0=%b", c, ce, clk_out[0]);
      end
      total++;
      if (ce !== m_ce || clk_out !== m_clk) begin
        bad++; $display("FAIL init_model c=%0d got %b/%b exp %b/%b", c, ce, clk_out, m_ce, m_clk);
      end
    end
  endtask

  task automatic test_reload();
    inc = {8'($urandom_range(255, 1)), 8'd128};
    load = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (locked !== 1'b0 || ce !== 2'b00 || clk_out !== 2'b00) begin
      bad++; $display("FAIL reload_edge got %b/%b/%b exp 0/00/00", locked, ce, clk_out);
    end
    for (int n = 1; n <= LC; n++) begin
      tick();
      total++;
      if (locked !== (n == LC) || ce !== 2'b00 || clk_out !== 2'b00) begin
        bad++; $display("FAIL reload_settle n=%0d got %b/%b/%b", n, locked, ce, clk_out);
      end
    end
    for (int c = 1; c <= 16; c++) begin
      tick();
      total++;
      if (ce[0] !== ((c % 2) == 0) || ce !== m_ce || clk_out !== m_clk) begin
        bad++; $display("FAIL reload_rate c=%0d got %b/%b exp %b/%b", c, ce, clk_out, m_ce, m_clk);
      end
    end
  endtask

  task automatic test_fractional();
    int cnt, last, gaperr;
    inc = {8'($urandom_range(255, 0)), 8'd96};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int n = 1; n <= LC; n++) tick();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL frac_lock got=%b exp=1", locked); end
    cnt = 0; last = 0; gaperr = 0;
    for (int c = 1; c <= 256; c++) begin
      tick();
      if (ce[0]) begin
        if (last > 0 && (c - last < 2 || c - last > 3)) gaperr++;
        last = c;
        cnt++;
      end
      total++;
      if (ce !== m_ce || clk_out !== m_clk) begin
        bad++; $display("FAIL frac_model c=%0d got %b/%b exp %b/%b", c, ce, clk_out, m_ce, m_clk);
      end
    end
    total++; if (cnt != 96) begin bad++; $display("FAIL frac_count got=%0d exp=96", cnt); end
    total++; if (gaperr != 0) begin bad++; $display("FAIL frac_gaps bad_gaps=%0d exp=0", gaperr); end
  endtask

  task automatic test_enable_gating();
    logic held;
    inc = {8'($urandom_range(255, 1)), 8'($urandom_range(255, 1))};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < LC + 20; c++) tick();
    en = 2'b10;
    held = clk_out[0];
    for (int c = 1; c <= 10; c++) begin
      tick();
      total++;
      if (ce[0] !== 1'b0 || clk_out[0] !== held || ce[1] !== m_ce[1] || clk_out[1] !== m_clk[1]) begin
        bad++; $display("FAIL gate_off c=%0d got %b/%b held=%b exp1 %b/%b", c, ce, clk_out, held, m_ce[1], m_clk[1]);
      end
    end
    en = 2'b11;
    for (int c = 1; c <= 40; c++) begin
      tick();
      total++;
      if (ce !== m_ce || clk_out !== m_clk) begin
        bad++; $display("FAIL gate_resume c=%0d got %b/%b exp %b/%b", c, ce, clk_out, m_ce, m_clk);
      end
    end
  endtask

  task automatic test_edge_incs();
    int cnt0, cnt1;
    inc = {8'd255, 8'd0};
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int n = 1; n <= LC; n++) tick();
    cnt0 = 0; cnt1 = 0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (ce[0]) cnt0++;
      if (c <= 256 && ce[1]) cnt1++;
      if (ce !== m_ce) begin
        total++; bad++; $display("FAIL edge_model c=%0d got %b exp %b", c, ce, m_ce);
      end
    end
    total++; if (cnt0 != 0) begin bad++; $display("FAIL edge_inc0 got=%0d exp=0", cnt0); end
    total++; if (cnt1 != 255) begin bad++; $display("FAIL edge_inc255 got=%0d exp=255", cnt1); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      inc = 16'($urandom);
      en  = 2'($urandom_range(3, 0));
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(7, 0) == 0) en = 2'($urandom_range(3, 0));
        if ($urandom_range(63, 0) == 0) begin
          load = 1'b1;
          inc  = 16'($urandom);
        end else begin
          load = 1'b0;
        end
        tick();
        total++;
        if (ce !== m_ce || clk_out !== m_clk || locked !== m_locked) begin
          bad++; $display("FAIL random r=%0d c=%0d got %b/%b/%b exp %b/%b/%b", r, c, ce, clk_out, locked, m_ce, m_clk, m_locked);
        end
      end
      load = 1'b0;
    end
  endtask

  task automatic test_async_and_settle_load();
    int got;
    en = 2'b11;
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (ce !== 2'b00 || clk_out !== 2'b00 || locked !== 1'b0) begin
      bad++; $display("FAIL async_reset got %b/%b/%b exp 00/00/0", ce, clk_out, locked);
    end
    model_reset();
    #2 rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      total++;
      if (ce !== m_ce || clk_out !== m_clk || locked !== m_locked) begin
        bad++; $display("FAIL init_restore c=%0d got %b/%b/%b exp %b/%b/%b", c, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
    end
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    tick(); tick();
    inc = 16'($urandom);
    load = 1'b1; tick(); load = 1'b0;
    tick(); tick();
    inc = {8'd64, 8'd32};
    load = 1'b1; tick(); load = 1'b0;
    got = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      total++;
      if (ce !== m_ce || clk_out !== m_clk || locked !== m_locked) begin
        bad++; $display("FAIL settle_model n=%0d got %b/%b/%b exp %b/%b/%b", n, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
      if (locked === 1'b1) begin got = n; break; end
    end
    total++; if (got != LC) begin bad++; $display("FAIL settle_reload_lock got=%0d exp=%0d", got, LC); end
  endtask

  initial begin
    test_reset();
    test_init_rates();
    test_reload();
    test_fractional();
    test_enable_gating();
    test_edge_incs();
    test_random();
    test_async_and_settle_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
